rpn_stack_engine: RTL
=====================

# rpn_stack_engine

Parametrised operand stack and ALU for the RPN calculator. It generalises the single stack-pointer register and the two-state write FSM into a full stack of WIDTH-bit operands, DEPTH entries deep. It supports push, pop, arithmetic, dup, swap and clear commands, with overflow, underflow and carry detection. It sits between the debounced key/switch front end and the HEX/LEDR display logic.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- DEPTH, 16, maximum stack entries (≥2); CW = $clog2(DEPTH+1)

- CLOCK_50  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command strobe; accepted only when ready=1
- cmd  in  3  000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 MUL, 101 DUP, 110 SWAP, 111 CLEAR
- data_in  in  WIDTH  PUSH operand, sampled at acceptance
- ready  out  1  high in S_IDLE only
- done  out  1  one-cycle pulse at command completion, including error completions
- tos  out  WIDTH  top of stack; 0 when count=0
- count  out  CW  number of entries, 0..DEPTH (the stack pointer)
- err_overflow  out  1  last completed command would exceed DEPTH
- err_underflow  out  1  last completed command lacked operands
- carry  out  1  last ADD/MUL result exceeded WIDTH bits, or last SUB borrowed

## Operation
- Storage: tos register holds entry 0. Array mem[0..DEPTH-2] holds entries below it: mem[count-2] is NOS, mem[0] is the bottom. mem uses a synchronous read.
- FSM states: S_IDLE, S_FETCH, S_EXEC.
  - S_IDLE: on cmd_valid, latch cmd and data_in, go to S_FETCH.
  - S_FETCH: register mem[count-2] into nos_q, go to S_EXEC. nos_q is don't-care when count<2.
  - S_EXEC: check for errors, update state, pulse done, go to S_IDLE.
- Error checks happen in S_EXEC. On any error, tos, count and mem are unchanged, carry is cleared, and the matching flag is set.
  - err_overflow: PUSH or DUP with count=DEPTH.
  - err_underflow: POP or DUP with count=0; ADD, SUB, MUL or SWAP with count<2.
- Flags update only on completion. A successful command clears both error flags.
- PUSH: if count>0, mem[count-1]←tos; tos←data_in; count+1.
- POP: tos←nos_q if count≥2, else 0; count−1.
- ADD, SUB, MUL: tos←(nos_q op tos)[WIDTH-1:0]; count−1.
  - SUB is nos_q − tos (RPN order), unsigned.
  - carry = bit WIDTH of the sum, or the borrow, or OR of product bits [2W-1:W].
- DUP: mem[count-1]←tos; count+1.
- SWAP: tos←nos_q; mem[count-2]←tos.
- CLEAR: tos←0; count←0; all flags←0; never errors.
- cmd_valid while ready=0 is ignored, not queued.
- carry is cleared by every non-arithmetic completion.

## Timing
- Reset (asynchronous, immediate): state S_IDLE, ready=1, done=0, tos=0, count=0, all flags 0. mem is not cleared; its contents are unreachable once count=0.
- Reset asserted mid-command aborts the command. No partial update survives and no done pulse occurs.
- Command sequence, with acceptance at edge k:
  - ready=0 after edge k.
  - S_FETCH during k..k+1.
  - S_EXEC during k+1..k+2.
  - Results and done=1 are visible after edge k+2.
  - ready=1 after edge k+2; done falls after edge k+3.
- Latency is 2 cycles. Maximum throughput is one command every 3 cycles, with the next acceptance earliest at edge k+3.
- mem write and tos update occur on the same edge, k+2. The S_FETCH read sees the pre-command array.

## Test plan
- Reset, then PUSH 5, PUSH 3, ADD:
  - count=1, tos=8, carry=0.
  - done pulses once per command, 3 cycles apart.
  - ready is low for exactly 2 cycles after each acceptance.
- WIDTH=8: PUSH 200, PUSH 100, ADD → tos=44, carry=1. Then PUSH 50, SUB → tos=250, carry=1 (44−50 borrows).
- DEPTH=4: PUSH 1,2,3,4, then PUSH 9:
  - err_overflow=1, count=4, tos=4.
  - Then POP ×4 → tos values 3,2,1,0, count=0.
  - A 5th POP → err_underflow=1, count=0.
- PUSH 7, PUSH 2, SWAP → tos=7. Then POP → tos=2. Then DUP, MUL → tos=4, count=1.
- Pulse cmd_valid=1 (PUSH 99) during S_FETCH of a prior PUSH 1 → ignored; count=1, tos=1.
- Assert reset_n=0 during S_EXEC of ADD with stack [9,4] → immediately count=0, tos=0, ready=1, no done pulse. Then PUSH 6 → tos=6, count=1.

Source files
------------

// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: WIDTH-bit operand stack with an RPN ALU and a three-state command FSM.
// Revision 1.0 - initial release.
`default_nettype none

module rpn_stack_engine #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] tos,
  output logic [CW-1:0]    count,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             carry
);

  localparam int AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1;

  localparam logic [2:0] CMD_PUSH  = 3'd0;
  localparam logic [2:0] CMD_POP   = 3'd1;
  localparam logic [2:0] CMD_ADD   = 3'd2;
  localparam logic [2:0] CMD_SUB   = 3'd3;
  localparam logic [2:0] CMD_MUL   = 3'd4;
  localparam logic [2:0] CMD_DUP   = 3'd5;
  localparam logic [2:0] CMD_SWAP  = 3'd6;
  localparam logic [2:0] CMD_CLEAR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] nos_q;

  logic [WIDTH-1:0] mem [0:DEPTH-2];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic               w_full;
  logic               w_has1;
  logic               w_has2;
  logic [AW-1:0]      w_top_idx;
  logic [AW-1:0]      w_nos_idx;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;

  assign w_full    = (count_q == CW'(DEPTH));
  assign w_has1    = (count_q != '0);
  assign w_has2    = (count_q >= CW'(2));
  assign w_top_idx = AW'(count_q - CW'(1));
  assign w_nos_idx = AW'(count_q - CW'(2));

  assign w_sum  = (WIDTH + 1)'(nos_q) + (WIDTH + 1)'(tos_q);
  assign w_diff = (WIDTH + 1)'(nos_q) - (WIDTH + 1)'(tos_q);
  assign w_prod = (2 * WIDTH)'(nos_q) * (2 * WIDTH)'(tos_q);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      data_q  <= '0;
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  // Array has no reset so it maps onto block RAM; entries above count are never observed.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (state_q == S_FETCH && w_has2) begin
      nos_q <= mem[w_nos_idx];
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    tos_d     = tos_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = w_top_idx;
    mem_wdata = tos_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = cmd;
          data_d  = data_in;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        carry_d = 1'b0;
        case (cmd_q)
          CMD_PUSH: begin
            if (w_full) begin
              ovf_d = 1'b1;
            end else begin
              mem_we  = w_has1;
              tos_d   = data_q;
              count_d = count_q + CW'(1);
            end
          end
          CMD_POP: begin
            if (!w_has1) begin
              unf_d = 1'b1;
            end else begin
              tos_d   = w_has2 ? nos_q : '0;
              count_d = count_q - CW'(1);
            end
          end
          CMD_ADD, CMD_SUB, CMD_MUL: begin
            if (!w_has2) begin
              unf_d = 1'b1;
            end else begin
              count_d = count_q - CW'(1);
              if (cmd_q == CMD_ADD) begin
                tos_d   = w_sum[WIDTH-1:0];
                carry_d = w_sum[WIDTH];
              end else if (cmd_q == CMD_SUB) begin
                tos_d   = w_diff[WIDTH-1:0];
                carry_d = w_diff[WIDTH];
              end else begin
                tos_d   = w_prod[WIDTH-1:0];
                carry_d = |w_prod[2*WIDTH-1:WIDTH];
              end
            end
          end
          CMD_DUP: begin
            if (!w_has1) begin
              unf_d = 1'b1;
            end else if (w_full) begin
              ovf_d = 1'b1;
            end else begin
              mem_we  = 1'b1;
              count_d = count_q + CW'(1);
            end
          end
          CMD_SWAP: begin
            if (!w_has2) begin
              unf_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = w_nos_idx;
              tos_d     = nos_q;
            end
          end
          CMD_CLEAR: begin
            tos_d   = '0;
            count_d = '0;
          end
          default: ;
        endcase
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready         = (state_q == S_IDLE);
  assign done          = done_q;
  assign tos           = tos_q;
  assign count         = count_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign carry         = carry_q;

endmodule

`default_nettype wire
